// File: rtl/shift_sequencer_if.sv
// Request/result bundle between instruction control and the shift sequencer.
// The master issues operations; the slave (the sequencer) returns y/busy/done.
interface shift_sequencer_if #(
    parameter int bus = 4,
    parameter int CW  = $clog2(bus)
) ();
    logic            start;
    logic [bus-1:0]  a;
    logic [CW-1:0]   shift_count;
    logic            dir;
    logic            rot;
    logic [bus-1:0]  y;
    logic            busy;
    logic            done;

    modport master (
        output start, a, shift_count, dir, rot,
        input  y, busy, done
    );

    modport slave (
        input  start, a, shift_count, dir, rot,
        output y, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: one 1-bit step per clock, result
// presented in y together with a single-cycle done pulse.
module shift_sequencer #(
    parameter int bus = 4,
    parameter int CW  = $clog2(bus)
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  sif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state;
    logic [bus-1:0] acc;
    logic [CW-1:0]  remaining;
    logic           dir_q;
    logic           rot_q;
    logic [bus-1:0] y_q;
    logic           busy_q;
    logic           done_q;
    logic [bus-1:0] acc_next;

    // Single-bit step: the fill bit is zero for logical shifts, the
    // bit falling off the opposite end for rotates.
    function automatic logic [bus-1:0] step_one(
        input logic [bus-1:0] v,
        input logic           right,
        input logic           rotate
    );
        logic fill;
        if (right) begin
            fill = rotate ? v[0] : 1'b0;
            return {fill, v[bus-1:1]};
        end else begin
            fill = rotate ? v[bus-1] : 1'b0;
            return {v[bus-2:0], fill};
        end
    endfunction

    assign acc_next = step_one(acc, dir_q, rot_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
            rot_q     <= 1'b0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sif.start) begin
                        acc       <= sif.a;
                        remaining <= sif.shift_count;
                        dir_q     <= sif.dir;
                        rot_q     <= sif.rot;
                        busy_q    <= 1'b1;
                        if (sif.shift_count == '0) begin
                            // Zero amount: the operand is the result as-is.
                            y_q    <= sif.a;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc       <= acc_next;
                    remaining <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        y_q    <= acc_next;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign sif.y    = y_q;
    assign sif.busy = busy_q;
    assign sif.done = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table of operations plus hand-written sequences,
// results checked through a scoreboard queue popped on each done pulse.
module tb_shift_sequencer;
    localparam int BUS = 4;
    localparam int CWB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_sequencer_if #(.bus(BUS), .CW(CWB)) sif ();

    shift_sequencer #(.bus(BUS), .CW(CWB)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        logic [BUS-1:0] y;
        int             cyc;
    } exp_t;

    typedef struct {
        logic [BUS-1:0] a;
        int             cnt;
        logic           dir;
        logic           rot;
        logic [BUS-1:0] y;
    } vec_t;

    exp_t sbq[$];

    function automatic logic [BUS-1:0] model(input logic [BUS-1:0] av, input int n,
                                             input logic d, input logic r);
        logic [BUS-1:0] res;
        if (n == 0) res = av;
        else if (!d && !r) res = av << n;
        else if (d && !r) res = av >> n;
        else if (!d) res = (av << n) | (av >> (BUS - n));
        else res = (av >> n) | (av << (BUS - n));
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && sif.done === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: y=%b at cycle %0d, no operation pending", sif.y, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (sif.y !== e.y || cyc != e.cyc || sif.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_result: y=%b cycle=%0d busy=%b, expected y=%b cycle=%0d busy=1",
                             sif.y, cyc, sif.busy, e.y, e.cyc);
                end
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic issue(input logic [BUS-1:0] av, input int n, input logic d,
                         input logic r, input logic [BUS-1:0] ey);
        @(negedge clk);
        sif.start       = 1'b1;
        sif.a           = av;
        sif.shift_count = CWB'(n);
        sif.dir         = d;
        sif.rot         = r;
        sbq.push_back('{y: ey, cyc: cyc + n + 1});
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        drain();
    endtask

    vec_t vecs[17];

    initial begin
        sif.start = 1'b0;
        sif.a = '0;
        sif.shift_count = '0;
        sif.dir = 1'b0;
        sif.rot = 1'b0;

        vecs[0]  = '{4'b0001, 0, 1'b0, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0001, 1, 1'b0, 1'b0, 4'b0010};
        vecs[2]  = '{4'b0001, 2, 1'b0, 1'b0, 4'b0100};
        vecs[3]  = '{4'b0001, 3, 1'b0, 1'b0, 4'b1000};
        vecs[4]  = '{4'b1000, 0, 1'b1, 1'b0, 4'b1000};
        vecs[5]  = '{4'b1000, 1, 1'b1, 1'b0, 4'b0100};
        vecs[6]  = '{4'b1000, 2, 1'b1, 1'b0, 4'b0010};
        vecs[7]  = '{4'b1000, 3, 1'b1, 1'b0, 4'b0001};
        vecs[8]  = '{4'b1011, 2, 1'b1, 1'b0, 4'b0010};
        vecs[9]  = '{4'b1001, 1, 1'b0, 1'b1, 4'b0011};
        vecs[10] = '{4'b1001, 3, 1'b1, 1'b1, 4'b0011};
        vecs[11] = '{4'b0110, 1, 1'b1, 1'b1, 4'b0011};
        vecs[12] = '{4'b1011, 3, 1'b0, 1'b1, 4'b1101};
        vecs[13] = '{4'b1011, 1, 1'b1, 1'b1, 4'b1101};
        vecs[14] = '{4'b1110, 3, 1'b1, 1'b1, 4'b1101};
        vecs[15] = '{4'b1110, 1, 1'b0, 1'b1, 4'b1101};
        vecs[16] = '{4'b1111, 3, 1'b0, 1'b0, 4'b1000};

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_y", 32'(sif.y), 32'd0);
        check("reset_busy", 32'(sif.busy), 32'd0);
        check("reset_done", 32'(sif.done), 32'd0);

        for (int i = 0; i < 17; i++)
            issue(vecs[i].a, vecs[i].cnt, vecs[i].dir, vecs[i].rot, vecs[i].y);

        for (int i = 0; i < 8; i++) begin
            logic [BUS-1:0] ra;
            int rn;
            logic rd, rr;
            ra = BUS'($urandom);
            rn = int'($urandom_range(0, BUS - 1));
            rd = 1'($urandom);
            rr = 1'($urandom);
            issue(ra, rn, rd, rr, model(ra, rn, rd, rr));
        end

        // Hold: y stays, done stays low over idle cycles
        issue(4'b0110, 2, 1'b0, 1'b1, 4'b1001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_y", 32'(sif.y), 32'b1001);
            check("hold_done", 32'(sif.done), 32'd0);
        end

        // Start held high while busy: only the first is taken until cycle 5
        @(negedge clk);
        sif.start = 1'b1;
        sif.a = 4'b0001;
        sif.shift_count = 2'd3;
        sif.dir = 1'b0;
        sif.rot = 1'b0;
        sbq.push_back('{y: 4'b1000, cyc: cyc + 4});
        @(posedge clk);
        #1;
        sif.a = 4'b1111;
        sif.shift_count = 2'd1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("busy_during_op", 32'(sif.busy), 32'd1);
        end
        @(negedge clk);
        check("idle_after_done", 32'(sif.busy), 32'd0);
        check("y_after_first", 32'(sif.y), 32'b1000);
        sbq.push_back('{y: 4'b1110, cyc: cyc + 2});
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        drain();

        // Reset mid-operation, with a start in the reset cycle
        @(negedge clk);
        sif.start = 1'b1;
        sif.a = 4'b0001;
        sif.shift_count = 2'd3;
        sif.dir = 1'b0;
        sif.rot = 1'b0;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sif.start = 1'b1;
        sif.a = 4'b1111;
        sif.shift_count = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_mid_y", 32'(sif.y), 32'd0);
            check("rst_mid_busy", 32'(sif.busy), 32'd0);
            check("rst_mid_done", 32'(sif.done), 32'd0);
        end
        issue(4'b0100, 2, 1'b1, 1'b0, 4'b0001);

        repeat (3) @(negedge clk);
        check("final_pending", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
